// File: rtl/step_dir_monitor.sv
// Receive-side monitor for an A4988 STEP/DIR/ENABLE interface: tracks signed
// position and step period, and flags pulse-width, DIR-setup and disabled-step violations.
module step_dir_monitor #(
    parameter int CLK_FREQ_HZ      = 50_000_000,
    parameter int SYNC_STAGES      = 2,
    parameter int MIN_PULSE_CYCLES = 50,
    parameter int DIR_SETUP_CYCLES = 10,
    parameter int POS_WIDTH        = 32,
    parameter int PERIOD_WIDTH     = 24
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        step_in,
    input  logic                        dir_in,
    input  logic                        enable_n_in,
    input  logic                        sleep_n_in,
    input  logic                        rst_n_in,
    input  logic                        clear_errors,
    output logic signed [POS_WIDTH-1:0] position,
    output logic                        step_strobe,
    output logic                        dir_latched,
    output logic [PERIOD_WIDTH-1:0]     period,
    output logic                        period_valid,
    output logic                        err_high_width,
    output logic                        err_low_width,
    output logic                        err_dir_setup,
    output logic                        err_disabled_step,
    output logic                        err_any
);

    // CLK_FREQ_HZ documents the intended clock only; SYNC_STAGES must be 2 or 3.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 3 || CLK_FREQ_HZ <= 0) begin : g_param_check
        $error("step_dir_monitor: illegal SYNC_STAGES or CLK_FREQ_HZ");
    end

    localparam int WIDTH_W = $clog2(MIN_PULSE_CYCLES + 1);
    localparam int DIR_W   = $clog2(DIR_SETUP_CYCLES + 1);

    localparam logic [WIDTH_W-1:0]      WIDTH_ONE = WIDTH_W'(1);
    localparam logic [WIDTH_W-1:0]      WIDTH_MAX = WIDTH_W'(MIN_PULSE_CYCLES);
    localparam logic [DIR_W-1:0]        DIR_ONE   = DIR_W'(1);
    localparam logic [DIR_W-1:0]        DIR_MAX   = DIR_W'(DIR_SETUP_CYCLES);
    localparam logic [PERIOD_WIDTH-1:0] PER_ONE   = PERIOD_WIDTH'(1);
    localparam logic [POS_WIDTH-1:0]    POS_ONE   = POS_WIDTH'(1);

    // A counter holding N in the edge cycle has seen N+1 clocks of the level,
    // so "shorter than the minimum" means a held count below minimum-1.
    localparam logic [WIDTH_W-1:0] WIDTH_OK = WIDTH_W'(MIN_PULSE_CYCLES - 1);
    localparam logic [DIR_W-1:0]   DIR_OK   = DIR_W'(DIR_SETUP_CYCLES - 1);

    localparam logic [1:0] ST_WAIT_FIRST = 2'd0;
    localparam logic [1:0] ST_HIGH       = 2'd1;
    localparam logic [1:0] ST_LOW        = 2'd2;

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic [4:0] pins;
    logic [4:0] sync_q [SYNC_STAGES];
    logic [4:0] s_pins;

    assign pins = {rst_n_in, sleep_n_in, enable_n_in, dir_in, step_in};

    // NOTE: synchronizer flops carry no reset so they keep tracking the pins
    // during reset; a STEP held high across reset release then shows no edge.
    always_ff @(posedge clk) begin
        sync_q[0] <= pins;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
        end
    end

    assign s_pins = sync_q[SYNC_STAGES-1];

    logic s_step, s_dir, s_en_n, s_sleep_n, s_rst_n;
    assign s_step    = s_pins[0];
    assign s_dir     = s_pins[1];
    assign s_en_n    = s_pins[2];
    assign s_sleep_n = s_pins[3];
    assign s_rst_n   = s_pins[4];

    // ------------------------------------------------------------------
    // Edge detection and event decode
    // ------------------------------------------------------------------
    logic step_q, dir_q;
    logic rise, fall, dir_change, active;
    logic width_short, dir_short;

    logic [1:0]              state;
    logic                    seen_rise;
    logic [WIDTH_W-1:0]      width_cnt;
    logic [DIR_W-1:0]        dir_cnt;
    logic [PERIOD_WIDTH-1:0] period_cnt;

    assign rise        = s_step & ~step_q;
    assign fall        = ~s_step & step_q;
    assign dir_change  = s_dir ^ dir_q;
    assign active      = ~s_en_n & s_sleep_n & s_rst_n;
    assign width_short = width_cnt < WIDTH_OK;
    // DIR toggling in the edge cycle itself means zero setup time.
    assign dir_short   = dir_change | (dir_cnt < DIR_OK);

    // Registered event flags, applied to the outputs one clock later.
    logic                    ev_step, ev_dir, ev_pv;
    logic [PERIOD_WIDTH-1:0] ev_period;
    logic                    ev_err_high, ev_err_low, ev_err_dir, ev_err_dis;

    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_q      <= s_step;
            dir_q       <= s_dir;
            state       <= ST_WAIT_FIRST;
            seen_rise   <= 1'b0;
            width_cnt   <= '0;
            dir_cnt     <= '0;
            period_cnt  <= '0;
            ev_step     <= 1'b0;
            ev_dir      <= 1'b0;
            ev_pv       <= 1'b0;
            ev_period   <= '0;
            ev_err_high <= 1'b0;
            ev_err_low  <= 1'b0;
            ev_err_dir  <= 1'b0;
            ev_err_dis  <= 1'b0;
        end else begin
            step_q <= s_step;
            dir_q  <= s_dir;

            case (state)
                ST_WAIT_FIRST: begin
                    if (rise)      state <= ST_HIGH;
                    else if (fall) state <= ST_LOW;
                end
                ST_HIGH: if (fall) state <= ST_LOW;
                ST_LOW:  if (rise) state <= ST_HIGH;
                default: state <= ST_WAIT_FIRST;
            endcase

            if (rise) seen_rise <= 1'b1;

            if (rise || fall)           width_cnt <= '0;
            else if (width_cnt != WIDTH_MAX) width_cnt <= width_cnt + WIDTH_ONE;

            if (dir_change)             dir_cnt <= '0;
            else if (dir_cnt != DIR_MAX) dir_cnt <= dir_cnt + DIR_ONE;

            if (rise)                   period_cnt <= PER_ONE;
            else if (period_cnt != '1)  period_cnt <= period_cnt + PER_ONE;

            ev_step     <= rise & active;
            ev_dir      <= s_dir;
            ev_pv       <= rise & seen_rise;
            ev_period   <= period_cnt;
            ev_err_high <= fall & (state == ST_HIGH) & width_short;
            ev_err_low  <= rise & (state == ST_LOW) & seen_rise & width_short;
            ev_err_dir  <= rise & dir_short;
            ev_err_dis  <= rise & ~active;
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic high_nxt, low_nxt, dir_nxt, dis_nxt;

    // Set wins over a simultaneous clear.
    always_comb begin
        high_nxt = ev_err_high | (err_high_width    & ~clear_errors);
        low_nxt  = ev_err_low  | (err_low_width     & ~clear_errors);
        dir_nxt  = ev_err_dir  | (err_dir_setup     & ~clear_errors);
        dis_nxt  = ev_err_dis  | (err_disabled_step & ~clear_errors);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            position          <= '0;
            step_strobe       <= 1'b0;
            dir_latched       <= 1'b0;
            period            <= '0;
            period_valid      <= 1'b0;
            err_high_width    <= 1'b0;
            err_low_width     <= 1'b0;
            err_dir_setup     <= 1'b0;
            err_disabled_step <= 1'b0;
            err_any           <= 1'b0;
        end else begin
            step_strobe  <= ev_step;
            period_valid <= ev_pv;
            if (ev_step) begin
                position    <= ev_dir ? position + POS_ONE : position - POS_ONE;
                dir_latched <= ev_dir;
            end
            if (ev_pv) period <= ev_period;
            err_high_width    <= high_nxt;
            err_low_width     <= low_nxt;
            err_dir_setup     <= dir_nxt;
            err_disabled_step <= dis_nxt;
            err_any           <= high_nxt | low_nxt | dir_nxt | dis_nxt;
        end
    end

endmodule

// File: tb/tb_step_dir_monitor.sv
// Directed self-checking bench for step_dir_monitor: a default-parameter instance
// plus a narrow instance for position wrap and period saturation.
module tb_step_dir_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Default-parameter instance
    logic        reset, step_in, dir_in, enable_n_in, sleep_n_in, rst_n_in, clear_errors;
    logic signed [31:0] position;
    logic [23:0] period;
    logic        step_strobe, dir_latched, period_valid;
    logic        err_high_width, err_low_width, err_dir_setup, err_disabled_step, err_any;

    step_dir_monitor dut (
        .clk(clk), .reset(reset), .step_in(step_in), .dir_in(dir_in),
        .enable_n_in(enable_n_in), .sleep_n_in(sleep_n_in), .rst_n_in(rst_n_in),
        .clear_errors(clear_errors), .position(position), .step_strobe(step_strobe),
        .dir_latched(dir_latched), .period(period), .period_valid(period_valid),
        .err_high_width(err_high_width), .err_low_width(err_low_width),
        .err_dir_setup(err_dir_setup), .err_disabled_step(err_disabled_step),
        .err_any(err_any)
    );

    // Narrow instance
    logic       b_reset, b_step, b_dir, b_en_n, b_sleep_n, b_rst_n, b_clear;
    logic signed [7:0] b_position;
    logic [7:0] b_period;
    logic       b_strobe, b_dir_latched, b_pv;
    logic       b_err_hw, b_err_lw, b_err_ds, b_err_dis, b_err_any;

    step_dir_monitor #(
        .MIN_PULSE_CYCLES(4), .DIR_SETUP_CYCLES(2), .POS_WIDTH(8), .PERIOD_WIDTH(8)
    ) dut_b (
        .clk(clk), .reset(b_reset), .step_in(b_step), .dir_in(b_dir),
        .enable_n_in(b_en_n), .sleep_n_in(b_sleep_n), .rst_n_in(b_rst_n),
        .clear_errors(b_clear), .position(b_position), .step_strobe(b_strobe),
        .dir_latched(b_dir_latched), .period(b_period), .period_valid(b_pv),
        .err_high_width(b_err_hw), .err_low_width(b_err_lw),
        .err_dir_setup(b_err_ds), .err_disabled_step(b_err_dis),
        .err_any(b_err_any)
    );

    int strobe_cnt = 0;
    int pv_cnt     = 0;
    int b_pv_cnt   = 0;
    always @(negedge clk) begin
        if (step_strobe)  strobe_cnt++;
        if (period_valid) pv_cnt++;
        if (b_pv)         b_pv_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        wait_clk(5);
        reset = 1'b0;
        wait_clk(20);
    endtask

    task automatic pulse(input int high, input int low);
        step_in = 1'b1;
        wait_clk(high);
        step_in = 1'b0;
        wait_clk(low);
    endtask

    task automatic b_pulse(input int high, input int low);
        b_step = 1'b1;
        wait_clk(high);
        b_step = 1'b0;
        wait_clk(low);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (position !== 32'sd0 || period !== 24'd0 || dir_latched !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: position=%0d period=%0d dir=%b, required 0 0 0", position, period, dir_latched);
        end
        checks++;
        if ({step_strobe, period_valid, err_high_width, err_low_width, err_dir_setup, err_disabled_step, err_any} !== 7'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b%b%b%b%b%b%b, required all 0", step_strobe, period_valid,
                     err_high_width, err_low_width, err_dir_setup, err_disabled_step, err_any);
        end
    endtask

    task automatic test_latency();
        apply_reset();
        step_in = 1'b1;
        wait_clk(3);
        checks++;
        if (step_strobe !== 1'b0) begin
            failures++;
            $display("FAIL latency_early: step_strobe=%b at edge k+2, required 0", step_strobe);
        end
        wait_clk(1);
        checks++;
        if (step_strobe !== 1'b1 || position !== 32'sd1) begin
            failures++;
            $display("FAIL latency_k3: step_strobe=%b position=%0d at edge k+3, required 1 and 1", step_strobe, position);
        end
        wait_clk(1);
        checks++;
        if (step_strobe !== 1'b0) begin
            failures++;
            $display("FAIL strobe_width: step_strobe=%b one cycle later, required 0", step_strobe);
        end
        wait_clk(95);
        step_in = 1'b0;
        wait_clk(100);
    endtask

    task automatic test_cw_pulses();
        int s0, p0;
        apply_reset();
        s0 = strobe_cnt;
        p0 = pv_cnt;
        repeat (10) pulse(100, 100);
        checks++;
        if (position !== 32'sd10) begin
            failures++;
            $display("FAIL cw_position: got %0d, required 10", position);
        end
        checks++;
        if (strobe_cnt - s0 !== 10 || pv_cnt - p0 !== 9) begin
            failures++;
            $display("FAIL cw_counts: strobes=%0d period_valids=%0d, required 10 and 9", strobe_cnt - s0, pv_cnt - p0);
        end
        checks++;
        if (period !== 24'd200 || err_any !== 1'b0) begin
            failures++;
            $display("FAIL cw_period: period=%0d err_any=%b, required 200 and 0", period, err_any);
        end
    endtask

    task automatic test_dir_setup(input int lead, input logic exp_err);
        apply_reset();
        repeat (4) pulse(100, 100);
        pulse(100, 100 - lead);
        dir_in = 1'b0;
        wait_clk(lead);
        repeat (8) pulse(100, 100);
        checks++;
        if (position !== -32'sd3 || dir_latched !== 1'b0) begin
            failures++;
            $display("FAIL dir_position lead=%0d: position=%0d dir_latched=%b, required -3 and 0", lead, position, dir_latched);
        end
        checks++;
        if (err_dir_setup !== exp_err || err_any !== exp_err) begin
            failures++;
            $display("FAIL dir_setup_flag lead=%0d: err_dir_setup=%b err_any=%b, required %b", lead, err_dir_setup, err_any, exp_err);
        end
        dir_in = 1'b1;
    endtask

    task automatic test_width_errors();
        apply_reset();
        pulse(100, 100);
        pulse(20, 100);
        checks++;
        if (err_high_width !== 1'b1 || err_low_width !== 1'b0 || position !== 32'sd2) begin
            failures++;
            $display("FAIL high_width: err_high=%b err_low=%b position=%0d, required 1 0 2", err_high_width, err_low_width, position);
        end
        pulse(100, 20);
        pulse(100, 100);
        checks++;
        if (err_low_width !== 1'b1 || err_any !== 1'b1 || position !== 32'sd4) begin
            failures++;
            $display("FAIL low_width: err_low=%b err_any=%b position=%0d, required 1 1 4", err_low_width, err_any, position);
        end
        clear_errors = 1'b1;
        wait_clk(1);
        clear_errors = 1'b0;
        checks++;
        if ({err_high_width, err_low_width, err_dir_setup, err_disabled_step, err_any} !== 5'b0) begin
            failures++;
            $display("FAIL clear_errors: flags=%b%b%b%b any=%b, required all 0", err_high_width, err_low_width,
                     err_dir_setup, err_disabled_step, err_any);
        end
    endtask

    task automatic test_disabled(input logic en_n, input logic sleep_n);
        int s0, p0;
        apply_reset();
        enable_n_in = en_n;
        sleep_n_in  = sleep_n;
        wait_clk(10);
        s0 = strobe_cnt;
        p0 = pv_cnt;
        repeat (4) pulse(100, 100);
        checks++;
        if (position !== 32'sd0 || strobe_cnt - s0 !== 0) begin
            failures++;
            $display("FAIL disabled_position en_n=%b sleep_n=%b: position=%0d strobes=%0d, required 0 0", en_n, sleep_n, position, strobe_cnt - s0);
        end
        checks++;
        if (err_disabled_step !== 1'b1 || pv_cnt - p0 !== 3) begin
            failures++;
            $display("FAIL disabled_flag en_n=%b sleep_n=%b: err=%b period_valids=%0d, required 1 and 3", en_n, sleep_n, err_disabled_step, pv_cnt - p0);
        end
        enable_n_in = 1'b0;
        sleep_n_in  = 1'b1;
    endtask

    task automatic test_reset_mid_pulse();
        int p0;
        apply_reset();
        repeat (2) pulse(100, 100);
        step_in = 1'b1;
        wait_clk(50);
        reset = 1'b1;
        wait_clk(1);
        checks++;
        if (position !== 32'sd0 || period !== 24'd0 || step_strobe !== 1'b0 || err_any !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_high: position=%0d period=%0d strobe=%b err_any=%b, required 0 0 0 0", position, period, step_strobe, err_any);
        end
        wait_clk(3);
        reset = 1'b0;
        wait_clk(30);
        step_in = 1'b0;
        wait_clk(20);
        p0 = pv_cnt;
        pulse(100, 100);
        checks++;
        if (pv_cnt - p0 !== 0 || err_low_width !== 1'b0 || position !== 32'sd1) begin
            failures++;
            $display("FAIL after_reset_edge: period_valids=%0d err_low=%b position=%0d, required 0 0 1", pv_cnt - p0, err_low_width, position);
        end
    endtask

    task automatic test_wrap();
        b_reset = 1'b1;
        wait_clk(5);
        b_reset = 1'b0;
        wait_clk(10);
        repeat (127) b_pulse(5, 5);
        checks++;
        if (b_position !== 8'sd127) begin
            failures++;
            $display("FAIL wrap_setup: position=%0d, required 127", b_position);
        end
        b_pulse(5, 5);
        checks++;
        if (b_position !== -8'sd128) begin
            failures++;
            $display("FAIL wrap_max_plus_one: position=%0d, required -128", b_position);
        end
        b_dir = 1'b0;
        wait_clk(5);
        b_pulse(5, 5);
        checks++;
        if (b_position !== 8'sd127 || b_err_any !== 1'b0) begin
            failures++;
            $display("FAIL wrap_min_minus_one: position=%0d err_any=%b, required 127 and 0", b_position, b_err_any);
        end
        b_dir = 1'b1;
    endtask

    task automatic test_period_saturation();
        int p0;
        b_reset = 1'b1;
        wait_clk(5);
        b_reset = 1'b0;
        wait_clk(10);
        b_pulse(5, 5);
        b_pulse(5, 5);
        checks++;
        if (b_period !== 8'd10) begin
            failures++;
            $display("FAIL period_normal: period=%0d, required 10", b_period);
        end
        wait_clk(300);
        p0 = b_pv_cnt;
        b_pulse(5, 5);
        checks++;
        if (b_period !== 8'hFF || b_pv_cnt - p0 !== 1) begin
            failures++;
            $display("FAIL period_saturate: period=%0d period_valids=%0d, required 255 and 1", b_period, b_pv_cnt - p0);
        end
    endtask

    initial begin
        reset = 1'b1; step_in = 1'b0; dir_in = 1'b1; enable_n_in = 1'b0;
        sleep_n_in = 1'b1; rst_n_in = 1'b1; clear_errors = 1'b0;
        b_reset = 1'b1; b_step = 1'b0; b_dir = 1'b1; b_en_n = 1'b0;
        b_sleep_n = 1'b1; b_rst_n = 1'b1; b_clear = 1'b0;

        test_reset();
        test_latency();
        test_cw_pulses();
        test_dir_setup(20, 1'b0);
        test_dir_setup(3, 1'b1);
        test_width_errors();
        test_disabled(1'b1, 1'b1);
        test_disabled(1'b0, 1'b0);
        test_reset_mid_pulse();
        test_wrap();
        test_period_saturation();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
